// File: rtl/sha256_chunk_iter_pkg.sv
// Shared SHA-256 constants, types and bit-mixing functions for the iterative chunk compressor.
// hash_t word 0 is H0 (the 'a' working variable); concatenations below list word 7 first.
package sha256_chunk_iter_pkg;

   typedef logic [7:0][31:0] hash_t;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam hash_t SHA256_IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                  32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
   localparam hash_t SHA224_IV = {32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
                                  32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8};

   function automatic logic [31:0] rotate_right(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return rotate_right(x, 7) ^ rotate_right(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return rotate_right(x, 17) ^ rotate_right(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] Sigma0(input logic [31:0] x);
      return rotate_right(x, 2) ^ rotate_right(x, 13) ^ rotate_right(x, 22);
   endfunction

   function automatic logic [31:0] Sigma1(input logic [31:0] x);
      return rotate_right(x, 6) ^ rotate_right(x, 11) ^ rotate_right(x, 25);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

// File: rtl/sha256_chunk_iter_round.sv
// One combinational SHA-256 round: rotates the working variables a..h and injects K[t] + W[t].
module sha256_round
   import sha256_chunk_iter_pkg::*;
(
   input  hash_t       state_i,
   input  logic [31:0] k_i,
   input  logic [31:0] w_i,
   output hash_t       state_o
);

   logic [31:0] t1;
   logic [31:0] t2;

   assign t1 = state_i[7] + Sigma1(state_i[4]) + ch(state_i[4], state_i[5], state_i[6]) + k_i + w_i;
   assign t2 = Sigma0(state_i[0]) + maj(state_i[0], state_i[1], state_i[2]);

   // word 0 = a ... word 7 = h; b..d and f..h are the old a..c and e..g
   assign state_o = {state_i[6:4], state_i[3] + t1, state_i[2:0], t1 + t2};

endmodule

// File: rtl/sha256_chunk_iter.sv
// Iterative SHA-256/224 chunk compressor: ROUNDS_PER_CYCLE rounds per clock, one chunk in flight,
// ready/valid on both sides with a same-edge retire+accept path out of DONE.
module sha256_chunk_iter
   import sha256_chunk_iter_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter int TAG_WIDTH        = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [511:0]         chunk,
   input  hash_t                current_hash,
   input  logic                 in_first,
   input  logic                 in_sha224,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output hash_t                next_hash,
   output logic [TAG_WIDTH-1:0] out_tag
);

   localparam int R = ROUNDS_PER_CYCLE;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : g_bad_rounds_per_cycle
      $error("sha256_chunk_iter: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   logic [1:0]           state_q, state_d;
   logic [5:0]           rnd_q, rnd_d;
   hash_t                h_start_q, h_start_d;
   hash_t                work_q, work_d;
   logic [15:0][31:0]    w_q, w_d;
   logic [TAG_WIDTH-1:0] tag_q, tag_d;
   hash_t                next_hash_q, next_hash_d;
   logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;

   logic        accept;
   hash_t       round_res;
   logic [31:0] ext [0:15+R];

   assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
   assign out_valid = (state_q == S_DONE);
   assign next_hash = next_hash_q;
   assign out_tag   = out_tag_q;
   assign accept    = in_valid && in_ready;

   // Schedule window extended by the R words consumed this cycle; ext[j] feeds round rnd+j.
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         ext[i] = w_q[i];
      end
      for (int i = 16; i < 16 + R; i++) begin
         ext[i] = sigma1(ext[i-2]) + ext[i-7] + sigma0(ext[i-15]) + ext[i-16];
      end
   end

   for (genvar gi = 0; gi < R; gi++) begin : g_round
      hash_t       st_in;
      hash_t       st_out;
      logic [31:0] k_w;

      if (gi == 0) begin : g_head
         assign st_in = work_q;
      end else begin : g_link
         assign st_in = g_round[gi-1].st_out;
      end

      assign k_w = K[rnd_q + 6'(gi)];

      sha256_round u_round (
         .state_i (st_in),
         .k_i     (k_w),
         .w_i     (ext[gi]),
         .state_o (st_out)
      );
   end

   assign round_res = g_round[R-1].st_out;

   always_comb begin
      state_d     = state_q;
      rnd_d       = rnd_q;
      h_start_d   = h_start_q;
      work_d      = work_q;
      w_d         = w_q;
      tag_d       = tag_q;
      next_hash_d = next_hash_q;
      out_tag_d   = out_tag_q;

      case (state_q)
         S_IDLE: ;
         S_RUN: begin
            work_d = round_res;
            rnd_d  = rnd_q + 6'(R);
            for (int i = 0; i < 16; i++) begin
               w_d[i] = ext[i+R];
            end
            if (rnd_q == 6'(64 - R)) begin
               for (int i = 0; i < 8; i++) begin
                  next_hash_d[i] = h_start_q[i] + round_res[i];
               end
               out_tag_d = tag_q;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Accept overrides the DONE->IDLE step so a retiring result and a new chunk share one edge.
      if (accept) begin
         h_start_d = in_first ? (in_sha224 ? SHA224_IV : SHA256_IV) : current_hash;
         work_d    = h_start_d;
         for (int i = 0; i < 16; i++) begin
            w_d[i] = chunk[511-32*i -: 32];
         end
         rnd_d   = '0;
         tag_d   = in_tag;
         state_d = S_RUN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rnd_q       <= '0;
         h_start_q   <= '0;
         work_q      <= '0;
         w_q         <= '0;
         tag_q       <= '0;
         next_hash_q <= '0;
         out_tag_q   <= '0;
      end else begin
         state_q     <= state_d;
         rnd_q       <= rnd_d;
         h_start_q   <= h_start_d;
         work_q      <= work_d;
         w_q         <= w_d;
         tag_q       <= tag_d;
         next_hash_q <= next_hash_d;
         out_tag_q   <= out_tag_d;
      end
   end

endmodule

// File: tb/tb_sha256_chunk_iter.sv
// Self-checking bench for sha256_chunk_iter at 1, 4 and 8 rounds per cycle against a plain
// FIPS-style compression model plus published digests.
`timescale 1ns/1ps
module tb_sha256_chunk_iter;

   typedef logic [7:0][31:0] hash_t;

   localparam int ND = 3;
   localparam int RPC [ND] = '{1, 4, 8};

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // Digests written H0 first, as published.
   localparam logic [255:0] IV256_BE = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] IV224_BE = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
   localparam logic [255:0] ABC256   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [223:0] ABC224   = 224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7;
   localparam logic [255:0] TWO_BLK  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [255:0] EMPTY256 = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

   localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
   localparam logic [511:0] TWO_B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] TWO_B2 = {480'h0, 32'h000001c0};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [ND-1:0] rst, in_valid, in_ready, in_first, in_sha224, out_valid, out_ready;
   logic [511:0]  chunk     [ND];
   hash_t         cur_hash  [ND];
   hash_t         next_hash [ND];
   logic [7:0]    in_tag    [ND];
   logic [7:0]    out_tag   [ND];

   for (genvar gi = 0; gi < ND; gi++) begin : g_dut
      sha256_chunk_iter #(
         .ROUNDS_PER_CYCLE (RPC[gi]),
         .TAG_WIDTH        (8)
      ) u_dut (
         .clk          (clk),
         .rst          (rst[gi]),
         .in_valid     (in_valid[gi]),
         .in_ready     (in_ready[gi]),
         .chunk        (chunk[gi]),
         .current_hash (cur_hash[gi]),
         .in_first     (in_first[gi]),
         .in_sha224    (in_sha224[gi]),
         .in_tag       (in_tag[gi]),
         .out_valid    (out_valid[gi]),
         .out_ready    (out_ready[gi]),
         .next_hash    (next_hash[gi]),
         .out_tag      (out_tag[gi])
      );
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic hash_t from_be(input logic [255:0] v);
      hash_t h;
      for (int i = 0; i < 8; i++) h[i] = v[255-32*i -: 32];
      return h;
   endfunction

   function automatic logic [255:0] to_be(input hash_t h);
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[255-32*i -: 32] = h[i];
      return v;
   endfunction

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Textbook compression: full 64-word schedule, then 64 rounds, then add back the input hash.
   function automatic hash_t ref_compress(input hash_t hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] t1, t2;
      hash_t       res;
      for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
              + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      for (int i = 0; i < 8; i++) v[i] = hin[i];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
         t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
         v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) res[i] = hin[i] + v[i];
      return res;
   endfunction

   function automatic hash_t rand_hash();
      hash_t h;
      for (int i = 0; i < 8; i++) h[i] = $urandom;
      return h;
   endfunction

   function automatic logic [511:0] rand_blk();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
      return b;
   endfunction

   task automatic wait_out(input int d, output int lat);
      lat = 0;
      while (!out_valid[d] && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // Present a chunk, let it be accepted, and return the result at the first out_valid cycle.
   task automatic run_chunk(input int d, input logic [511:0] blk, input hash_t hin, input bit first,
                            input bit s224, input logic [7:0] tag,
                            output hash_t got, output logic [7:0] gtag, output int lat);
      int n = 0;
      chunk[d] = blk; cur_hash[d] = hin; in_first[d] = first; in_sha224[d] = s224;
      in_tag[d] = tag; in_valid[d] = 1'b1;
      while (!in_ready[d] && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      wait_out(d, lat);
      got  = next_hash[d];
      gtag = out_tag[d];
   endtask

   task automatic check_chunk(input int d, input string name, input logic [511:0] blk, input hash_t hin,
                              input bit first, input bit s224, output hash_t got);
      logic [7:0] tag, gtag;
      int         lat;
      hash_t      expv;
      tag = 8'($urandom);
      run_chunk(d, blk, hin, first, s224, tag, got, gtag, lat);
      expv = ref_compress(first ? (s224 ? from_be(IV224_BE) : from_be(IV256_BE)) : hin, blk);
      check_eq({name, " latency"}, 256'(lat), 256'(64 / RPC[d]));
      check_eq({name, " hash"}, got, expv);
      check_eq({name, " tag"}, 256'(gtag), 256'(tag));
      @(posedge clk); #1;
   endtask

   task automatic run_suite(input int d);
      string        p;
      hash_t        got, hin, expa, expb, r1;
      logic [511:0] blka, blkb;
      logic [255:0] be;
      logic [7:0]   taga, tagb, gtag;
      int           lat, bad;
      bit           first, s224;
      p = $sformatf("R%0d", RPC[d]);

      check_chunk(d, {p, " abc256"}, ABC_BLK, rand_hash(), 1'b1, 1'b0, got);
      check_eq({p, " abc256 digest"}, got, from_be(ABC256));

      check_chunk(d, {p, " abc224"}, ABC_BLK, rand_hash(), 1'b1, 1'b1, got);
      be = to_be(got);
      check_eq({p, " abc224 digest"}, {32'h0, be[255:32]}, {32'h0, ABC224});

      check_chunk(d, {p, " two-block b1"}, TWO_B1, rand_hash(), 1'b1, 1'b0, got);
      r1 = ref_compress(from_be(IV256_BE), TWO_B1);
      check_chunk(d, {p, " two-block b2"}, TWO_B2, r1, 1'b0, 1'b0, got);
      check_eq({p, " two-block digest"}, got, from_be(TWO_BLK));

      // Backpressure: hold the result 20 cycles while a competing chunk waits, then retire+accept.
      out_ready[d] = 1'b0;
      blka = rand_blk(); hin = rand_hash(); taga = 8'($urandom);
      run_chunk(d, blka, hin, 1'b0, 1'b0, taga, got, gtag, lat);
      expa = ref_compress(hin, blka);
      check_eq({p, " bp first latency"}, 256'(lat), 256'(64 / RPC[d]));
      check_eq({p, " bp first hash"}, got, expa);
      blkb = rand_blk(); hin = rand_hash(); tagb = 8'($urandom);
      chunk[d] = blkb; cur_hash[d] = hin; in_first[d] = 1'b0; in_tag[d] = tagb; in_valid[d] = 1'b1;
      bad = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (!out_valid[d] || in_ready[d] || next_hash[d] !== expa || out_tag[d] !== taga) bad++;
      end
      check_eq({p, " bp hold unstable cycles"}, 256'(bad), 256'(0));
      out_ready[d] = 1'b1;
      #1;
      check_eq({p, " bp in_ready follows out_ready"}, 256'(in_ready[d]), 256'(1));
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      check_eq({p, " bp retired on accept edge"}, 256'(out_valid[d]), 256'(0));
      wait_out(d, lat);
      expb = ref_compress(hin, blkb);
      check_eq({p, " bp second latency"}, 256'(lat), 256'(64 / RPC[d]));
      check_eq({p, " bp second hash"}, next_hash[d], expb);
      check_eq({p, " bp second tag"}, 256'(out_tag[d]), 256'(tagb));
      @(posedge clk); #1;

      // Reset around round 30 of an in-flight chunk; outputs must clear without a clock edge.
      chunk[d] = rand_blk(); cur_hash[d] = rand_hash(); in_first[d] = 1'b0;
      in_tag[d] = 8'($urandom); in_valid[d] = 1'b1;
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      repeat (30 / RPC[d]) @(posedge clk);
      #2;
      rst[d] = 1'b1;
      #1;
      check_eq({p, " rst out_valid"}, 256'(out_valid[d]), 256'(0));
      check_eq({p, " rst next_hash"}, next_hash[d], 256'(0));
      check_eq({p, " rst out_tag"}, 256'(out_tag[d]), 256'(0));
      @(posedge clk); #4;
      rst[d] = 1'b0;
      @(posedge clk); #1;
      check_eq({p, " post-rst in_ready"}, 256'(in_ready[d]), 256'(1));
      check_chunk(d, {p, " empty"}, EMPTY_BLK, rand_hash(), 1'b1, 1'b0, got);
      check_eq({p, " empty digest"}, got, from_be(EMPTY256));

      // Random chunks, chaining each result into the next hash input.
      hin = rand_hash();
      for (int k = 0; k < 10; k++) begin
         first = ($urandom % 3) == 0;
         s224  = 1'($urandom);
         check_chunk(d, $sformatf("%s rnd%0d", p, k), rand_blk(), hin, first, s224, got);
         hin = got;
         repeat ($urandom_range(2)) begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      rst = '1; in_valid = '0; in_first = '0; in_sha224 = '0; out_ready = '1;
      for (int d = 0; d < ND; d++) begin
         chunk[d] = '0; cur_hash[d] = '0; in_tag[d] = '0;
      end
      repeat (3) @(posedge clk);
      #4 rst = '0;
      @(posedge clk); #1;
      for (int d = 0; d < ND; d++) begin
         check_eq($sformatf("R%0d reset in_ready", RPC[d]), 256'(in_ready[d]), 256'(1));
         check_eq($sformatf("R%0d reset out_valid", RPC[d]), 256'(out_valid[d]), 256'(0));
         check_eq($sformatf("R%0d reset next_hash", RPC[d]), next_hash[d], 256'(0));
         check_eq($sformatf("R%0d reset out_tag", RPC[d]), 256'(out_tag[d]), 256'(0));
      end
      for (int d = 0; d < ND; d++) run_suite(d);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
